grf_wb_queue: RTL and testbench

Write-back queue between result producers and the general register file's single write port. It accepts register results from the pipeline W stage and from the multi-cycle multiply/divide unit, possibly both in one cycle. Results are buffered in program-accept order and drained at one register write per cycle. A combinational snoop port lets the decode stage forward the newest pending value of a register that has not yet reached the file.

---
 rtl/grf_wb_queue.sv | 95 +++++++++
 tb/tb_grf_wb_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: write-back queue feeding the single GRF write port.
// Dual-source push, one drain per cycle, newest-first decode snoop.
module grf_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [31:0]             w_pc,
  input  logic [4:0]              w_addr,
  input  logic [31:0]             w_data,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [31:0]             md_pc,
  input  logic [4:0]              md_addr,
  input  logic [31:0]             md_data,
  output logic                    RegWrite,
  output logic [31:0]             PC,
  output logic [4:0]              A3,
  output logic [31:0]             WD,
  input  logic [4:0]              snp_addr,
  output logic                    snp_hit,
  output logic [31:0]             snp_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q   [DEPTH];
  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] md_slot;
  logic [AW-1:0] idx;
  logic          pop;
  logic          w_keep;
  logic          md_keep;

  assign pop      = (count != '0);
  assign RegWrite = pop;
  assign PC       = pop ? pc_q[head]   : '0;
  assign A3       = pop ? addr_q[head] : '0;
  assign WD       = pop ? data_q[head] : '0;

  // r0 writes are acknowledged but never stored or counted
  assign w_ready  = (count < FULL);
  assign w_keep   = w_valid & w_ready & (w_addr != 5'd0);
  assign md_ready = ((count + CW'(w_keep)) < FULL);
  assign md_keep  = md_valid & md_ready & (md_addr != 5'd0);
  assign md_slot  = tail + AW'(w_keep);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(w_keep) + AW'(md_keep);
      count <= count + CW'(w_keep) + CW'(md_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_keep) begin
      pc_q[tail]   <= w_pc;
      addr_q[tail] <= w_addr;
      data_q[tail] <= w_data;
    end
    if (md_keep) begin
      pc_q[md_slot]   <= md_pc;
      addr_q[md_slot] <= md_addr;
      data_q[md_slot] <= md_data;
    end
  end

  // oldest-to-newest scan; the last match is the youngest entry
  always_comb begin
    snp_hit  = 1'b0;
    snp_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (snp_addr != 5'd0 && CW'(i) < count &&
          addr_q[idx] == snp_addr) begin
        snp_hit  = 1'b1;
        snp_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// tb_grf_wb_queue: directed scoreboard bench for grf_wb_queue.
// Reference queue predicts ready, drain, count and snoop each cycle.
module tb_grf_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic w_valid, w_ready;
  logic [31:0] w_pc, w_data;
  logic [4:0] w_addr;
  logic md_valid, md_ready;
  logic [31:0] md_pc, md_data;
  logic [4:0] md_addr;
  logic RegWrite;
  logic [31:0] PC, WD;
  logic [4:0] A3;
  logic [4:0] snp_addr;
  logic snp_hit;
  logic [31:0] snp_data;
  logic [$clog2(DEPTH):0] count;

  ent_t sb[$];
  int ncmp = 0;
  int nerr = 0;
  bit w_acc, md_acc;
  int mk;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_pc(md_pc), .md_addr(md_addr), .md_data(md_data),
    .RegWrite(RegWrite), .PC(PC), .A3(A3), .WD(WD),
    .snp_addr(snp_addr), .snp_hit(snp_hit),
    .snp_data(snp_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic setw(logic [31:0] pc, logic [4:0] a,
                      logic [31:0] d);
    w_valid = 1'b1; w_pc = pc; w_addr = a; w_data = d;
  endtask

  task automatic setmd(logic [31:0] pc, logic [4:0] a,
                       logic [31:0] d);
    md_valid = 1'b1; md_pc = pc; md_addr = a; md_data = d;
  endtask

  task automatic clr();
    w_valid = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic cycle();
    int n, wk;
    logic ew, em, hit;
    logic [31:0] sd;
    @(negedge clk);
    n  = sb.size();
    ew = (n < DEPTH);
    wk = (w_valid === 1'b1 && ew && w_addr != 5'd0) ? 1 : 0;
    em = ((n + wk) < DEPTH);
    chk("w_ready", w_ready, ew);
    chk("md_ready", md_ready, em);
    chk("count", count, n);
    if (n != 0) begin
      chk("RegWrite", RegWrite, 1);
      chk("A3", A3, sb[0].addr);
      chk("WD", WD, sb[0].data);
      chk("PC", PC, sb[0].pc);
    end else begin
      chk("RegWrite_idle", RegWrite, 0);
      chk("A3_idle", A3, 0);
      chk("WD_idle", WD, 0);
      chk("PC_idle", PC, 0);
    end
    hit = 1'b0;
    sd  = '0;
    if (snp_addr != 5'd0)
      foreach (sb[i])
        if (sb[i].addr == snp_addr) begin
          hit = 1'b1;
          sd  = sb[i].data;
        end
    chk("snp_hit", snp_hit, hit);
    chk("snp_data", snp_data, sd);
    w_acc  = (w_valid === 1'b1) && ew;
    md_acc = (md_valid === 1'b1) && em;
    if (n != 0) void'(sb.pop_front());
    if (w_acc && w_addr != 5'd0)
      sb.push_back('{w_pc, w_addr, w_data});
    if (md_acc && md_addr != 5'd0)
      sb.push_back('{md_pc, md_addr, md_data});
    @(posedge clk);
    #1;
  endtask

  task automatic next_md();
    mk++;
    if (mk < 3)
      setmd(32'h300 + 32'(mk * 4), 5'(20 + mk),
            32'h2000_0000 + 32'(mk));
    else
      md_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    w_valid = 0; w_pc = 0; w_addr = 0; w_data = 0;
    md_valid = 0; md_pc = 0; md_addr = 0; md_data = 0;
    snp_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 1'b1;
    cycle();

    // single source
    setw(32'h100, 5'd5, 32'h1111_1111);
    cycle();
    clr();
    chk("single_A3", A3, 5);
    chk("single_WD", WD, 32'h1111_1111);
    chk("single_cnt", count, 1);
    cycle();
    chk("single_empty", count, 0);

    // dual push ordering
    setw(32'h110, 5'd3, 32'hA);
    setmd(32'h114, 5'd4, 32'hB);
    cycle();
    clr();
    chk("dual_peak", count, 2);
    chk("dual_first", A3, 3);
    repeat (3) cycle();

    // fill and back-pressure
    mk = 0;
    setmd(32'h300, 5'd20, 32'h2000_0000);
    for (int k = 0; k < 3; k++) begin
      setw(32'h200 + 32'(k * 4), 5'(10 + k),
           32'h1000_0000 + 32'(k));
      cycle();
      if (md_acc) next_md();
    end
    w_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0 && !md_valid) break;
      cycle();
      if (md_acc) next_md();
    end
    chk("fill_drained", sb.size() + int'(md_valid), 0);

    // register 0
    snp_addr = 5'd0;
    setw(32'h400, 5'd0, 32'hDEAD);
    cycle();
    clr();
    chk("r0_cnt", count, 0);
    chk("r0_nowrite", RegWrite, 0);
    chk("r0_snp", snp_hit, 0);

    // snoop newest across pointer wrap
    snp_addr = 5'd7;
    setw(32'h500, 5'd9, 32'h99);
    setmd(32'h504, 5'd10, 32'hAA);
    cycle();
    setw(32'h508, 5'd7, 32'h1);
    setmd(32'h50C, 5'd2, 32'h9);
    cycle();
    md_valid = 1'b0;
    setw(32'h510, 5'd7, 32'h2);
    cycle();
    clr();
    chk("snp_new_hit", snp_hit, 1);
    chk("snp_new_data", snp_data, 2);
    repeat (4) cycle();
    chk("snp_gone", snp_hit, 0);

    // reset mid-drain
    setw(32'h600, 5'd11, 32'h61);
    setmd(32'h604, 5'd12, 32'h62);
    cycle();
    setw(32'h608, 5'd13, 32'h63);
    setmd(32'h60C, 5'd14, 32'h64);
    cycle();
    clr();
    chk("pre_rst_cnt", count, 3);
    #3 reset = 1'b0;
    #1;
    chk("rst_cnt", count, 0);
    chk("rst_wr", RegWrite, 0);
    chk("rst_A3", A3, 0);
    sb.delete();
    cycle();
    #2 reset = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
